// File: rtl/can_pkg.sv
// Shared CAN definitions for the receive front end: field widths, frame record
// and the filter-hit tag that marks pass-through acceptance.
package can_pkg;

    localparam int CAN_ID_W   = 11;
    localparam int CAN_DLC_W  = 4;
    localparam int CAN_DATA_W = 64;

    typedef struct packed {
        logic [CAN_ID_W-1:0]   id;
        logic [CAN_DLC_W-1:0]  dlc;
        logic [CAN_DATA_W-1:0] data;
    } can_frame_t;

    // Sliced down to the hit-tag width by users; all-ones in any width.
    localparam logic [7:0] HIT_PASS = 8'hFF;

endpackage

// File: rtl/can_sync_fifo.sv
// Generic show-ahead register FIFO: head entry is always visible on dout_o,
// pop on empty is ignored, push on full is accepted only together with a pop.
module can_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pop_ok   = pop_i & ~empty_o;
        push_ok  = push_i & (~full_o | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok) count_d = count_q + 1'b1;
        if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q gates validity and the consumer masks the head when empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/can_rx_filter_fifo.sv
// CAN receive front end: edge-detects rx_val, runs ID/mask acceptance filters
// with lowest-index priority and queues accepted frames with their hit tag.
module can_rx_filter_fifo
    import can_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int DATA_W      = 64,
    localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    localparam int HIT_W = $clog2(NUM_FILTERS) + 1,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic                 cfg_en,
    input  logic [CAN_ID_W-1:0]  cfg_id,
    input  logic [CAN_ID_W-1:0]  cfg_mask,
    input  logic                 rx_val,
    input  logic [CAN_ID_W-1:0]  rx_id,
    input  logic [CAN_DLC_W-1:0] rx_dlc,
    input  logic [DATA_W-1:0]    rx_data,
    input  logic                 rd_en,
    output logic                 rd_valid,
    output logic [CAN_ID_W-1:0]  rd_id,
    output logic [CAN_DLC_W-1:0] rd_dlc,
    output logic [DATA_W-1:0]    rd_data,
    output logic [HIT_W-1:0]     rd_hit,
    output logic [CNT_W-1:0]     count,
    output logic                 ovf,
    output logic [7:0]           drop_cnt,
    input  logic                 ovf_clr
);

    typedef struct packed {
        logic [CAN_ID_W-1:0]  id;
        logic [CAN_DLC_W-1:0] dlc;
        logic [DATA_W-1:0]    data;
        logic [HIT_W-1:0]     hit;
    } entry_t;

    logic [NUM_FILTERS-1:0] flt_en_q;
    logic [CAN_ID_W-1:0]    flt_id_q   [NUM_FILTERS];
    logic [CAN_ID_W-1:0]    flt_mask_q [NUM_FILTERS];
    logic                   rx_val_q;
    logic                   ovf_q, ovf_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;

    logic             frame_evt, hit_found, accept, drop;
    logic [HIT_W-1:0] hit_idx;
    entry_t           wr_entry, head_entry;
    logic             fifo_full, fifo_empty;
    logic [$bits(entry_t)-1:0] fifo_dout;

    assign frame_evt = rx_val & ~rx_val_q;

    // Scan downwards so the lowest-index hit is the last one written.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
            if (flt_en_q[k] && ((rx_id ^ flt_id_q[k]) & flt_mask_q[k]) == '0) begin
                hit_found = 1'b1;
                hit_idx   = HIT_W'(k);
            end
        end
    end

    always_comb begin
        accept        = frame_evt & (~(|flt_en_q) | hit_found);
        drop          = accept & fifo_full & ~rd_en;
        wr_entry.id   = rx_id;
        wr_entry.dlc  = rx_dlc;
        wr_entry.data = rx_data;
        wr_entry.hit  = (|flt_en_q) ? hit_idx : HIT_PASS[HIT_W-1:0];
        ovf_d         = ovf_q;
        drop_cnt_d    = drop_cnt_q;
        if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = (drop_cnt_d == 8'hFF) ? 8'hFF : drop_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_val_q   <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            flt_en_q   <= '0;
            for (int k = 0; k < NUM_FILTERS; k++) begin
                flt_id_q[k]   <= '0;
                flt_mask_q[k] <= '0;
            end
        end else begin
            rx_val_q   <= rx_val;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            for (int k = 0; k < NUM_FILTERS; k++) begin
                if (cfg_we && cfg_idx == IDX_W'(k)) begin
                    flt_en_q[k]   <= cfg_en;
                    flt_id_q[k]   <= cfg_id;
                    flt_mask_q[k] <= cfg_mask;
                end
            end
        end
    end

    can_sync_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (accept),
        .pop_i  (rd_en),
        .din_i  (wr_entry),
        .dout_o (fifo_dout),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(count)
    );

    assign head_entry = fifo_empty ? '0 : entry_t'(fifo_dout);
    assign rd_valid   = ~fifo_empty;
    assign rd_id      = head_entry.id;
    assign rd_dlc     = head_entry.dlc;
    assign rd_data    = head_entry.data;
    assign rd_hit     = head_entry.hit;
    assign ovf        = ovf_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_can_rx_filter_fifo.sv
// Directed bench for can_rx_filter_fifo: filtering, priority, pass-through,
// overflow, full push/pop, level rx_val and asynchronous reset.
module tb_can_rx_filter_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en;
    logic [10:0] cfg_id, cfg_mask;
    logic        rx_val;
    logic [10:0] rx_id;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        rd_en;
    logic        rd_valid;
    logic [10:0] rd_id;
    logic [3:0]  rd_dlc;
    logic [63:0] rd_data;
    logic [2:0]  rd_hit;
    logic [3:0]  count;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        ovf_clr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    can_rx_filter_fifo #(.NUM_FILTERS(4), .FIFO_DEPTH(8), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_id(cfg_id), .cfg_mask(cfg_mask),
        .rx_val(rx_val), .rx_id(rx_id), .rx_dlc(rx_dlc), .rx_data(rx_data),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_id(rd_id), .rd_dlc(rd_dlc), .rd_data(rd_data),
        .rd_hit(rd_hit), .count(count), .ovf(ovf), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic en, input logic [10:0] id, input logic [10:0] mask);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_id = id; cfg_mask = mask;
        tick();
        cfg_we = 1'b0;
    endtask

    // One-cycle pulse followed by an idle cycle so the next call is a fresh edge.
    task automatic send(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        rx_val = 1'b1; rx_id = id; rx_dlc = dlc; rx_data = data;
        tick();
        rx_val = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        logic [10:0] id;
        rst = 1'b1; cfg_we = 0; cfg_idx = 0; cfg_en = 0; cfg_id = 0; cfg_mask = 0;
        rx_val = 0; rx_id = 0; rx_dlc = 0; rx_data = 0; rd_en = 0; ovf_clr = 0;
        #12;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_rd_id", rd_id, 0);
        check("rst_rd_hit", rd_hit, 0);
        rst = 1'b0;
        tick();

        // Pass-through with all filters disabled
        send(11'h7FF, 4'd8, 64'h0123456789ABCDEF);
        check("pt_count", count, 1);
        check("pt_rd_id", rd_id, 11'h7FF);
        check("pt_rd_dlc", rd_dlc, 8);
        check("pt_rd_data", rd_data, 64'h0123456789ABCDEF);
        check("pt_rd_hit", rd_hit, 3'b111);
        pop();
        check("pt_empty_valid", rd_valid, 0);
        check("pt_empty_id", rd_id, 0);
        send(11'h123, 4'hF, 64'h55);
        check("dlc15_verbatim", rd_dlc, 4'hF);
        pop();

        // Single filter
        cfg(2'd0, 1'b1, 11'h1A0, 11'h7F0);
        send(11'h1A1, 4'd1, 64'hAA);
        send(11'h2B2, 4'd1, 64'hBB);
        check("sf_count", count, 1);
        check("sf_rd_id", rd_id, 11'h1A1);
        check("sf_rd_hit", rd_hit, 0);
        check("sf_drop_cnt", drop_cnt, 0);
        check("sf_ovf", ovf, 0);
        pop();

        // Priority
        cfg(2'd1, 1'b1, 11'h3C3, 11'h7FF);
        cfg(2'd2, 1'b1, 11'h000, 11'h000);
        send(11'h3C3, 4'd2, 64'h1);
        check("pri_hit1", rd_hit, 1);
        pop();
        send(11'h055, 4'd2, 64'h2);
        check("pri_hit2", rd_hit, 2);
        pop();

        // Frame in the same cycle as a config write sees the old filter set
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_en = 1'b0; cfg_id = 0; cfg_mask = 0;
        rx_val = 1'b1; rx_id = 11'h555; rx_dlc = 0; rx_data = 0;
        tick();
        cfg_we = 1'b0; rx_val = 1'b0;
        tick();
        send(11'h556, 4'd0, 64'h0);
        check("cfg_old_count", count, 1);
        check("cfg_old_id", rd_id, 11'h555);
        check("cfg_old_hit", rd_hit, 2);
        pop();
        cfg(2'd2, 1'b1, 11'h000, 11'h000);

        // Overflow: 9 frames into 8 entries
        for (int i = 0; i < 9; i++) begin
            id = 11'h100 + 11'(i);
            send(id, 4'd3, 64'(i));
        end
        check("ovf_count", count, 8);
        check("ovf_flag", ovf, 1);
        check("ovf_drop_cnt", drop_cnt, 1);
        check("ovf_head", rd_id, 11'h100);
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_id", rd_id, 64'h100 + 64'(i));
            pop();
        end
        check("ovf_drained_valid", rd_valid, 0);
        pop();
        check("pop_empty_count", count, 0);
        send(11'h110, 4'd0, 64'h0);
        check("after_empty_pop_id", rd_id, 11'h110);
        check("after_empty_pop_count", count, 1);
        pop();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_ovf", ovf, 0);
        check("clr_drop_cnt", drop_cnt, 0);

        // Clear coinciding with a drop, then full with simultaneous pop
        for (int i = 0; i < 8; i++) begin
            id = 11'h300 + 11'(i);
            send(id, 4'd1, 64'(i));
        end
        check("full_count", count, 8);
        rx_val = 1'b1; rx_id = 11'h308; ovf_clr = 1'b1;
        tick();
        rx_val = 1'b0; ovf_clr = 1'b0;
        tick();
        check("clr_vs_drop_ovf", ovf, 1);
        check("clr_vs_drop_cnt", drop_cnt, 1);
        rx_val = 1'b1; rx_id = 11'h200; rd_en = 1'b1;
        tick();
        rx_val = 1'b0; rd_en = 1'b0;
        tick();
        check("fullpop_count", count, 8);
        check("fullpop_drop_cnt", drop_cnt, 1);
        check("fullpop_head", rd_id, 11'h301);
        for (int i = 1; i < 8; i++) begin
            check("fullpop_drain_id", rd_id, 64'h300 + 64'(i));
            pop();
        end
        check("fullpop_last", rd_id, 11'h200);
        pop();
        check("fullpop_empty", rd_valid, 0);

        // Level rx_val yields a single event
        rx_val = 1'b1; rx_id = 11'h400; rx_dlc = 4'd4;
        repeat (5) tick();
        rx_val = 1'b0;
        tick();
        check("level_count", count, 1);
        check("level_id", rd_id, 11'h400);
        send(11'h401, 4'd0, 64'h0);
        send(11'h402, 4'd0, 64'h0);
        check("pre_rst_count", count, 3);

        // Asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", rd_valid, 0);
        check("async_rst_count", count, 0);
        check("async_rst_id", rd_id, 0);
        #2 rst = 1'b0;
        tick();
        send(11'h7AB, 4'd0, 64'h0);
        check("post_rst_count", count, 1);
        check("post_rst_passthru_hit", rd_hit, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
